// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared definitions for the divider-side monitor blocks
// Contents:
//   state_t    measurement FSM states (IDLE, ARM, HIGH, LOW)
//   DEF_CNT_W  default width of the high/low duration counters
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/div_edge_det.sv
// rtl/div_edge_det.sv - one-cycle rise/fall detector for a clk-synchronous divided signal
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   div_in  in   divided signal, already in the clk domain
//   rise    out  div_in is 1 this cycle and was 0 last cycle
//   fall    out  div_in is 0 this cycle and was 1 last cycle
module div_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic div_in,
  output logic rise,
  output logic fall
);

  logic div_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_d <= 1'b0;
    end else begin
      div_d <= div_in;
    end
  end

  // Combinational from the live input so the edge cycle itself counts
  // as cycle 1 of the new level.
  assign rise = div_in & ~div_d;
  assign fall = ~div_in & div_d;

endmodule

// File: rtl/div_freq_meter.sv
// rtl/div_freq_meter.sv - high/low/period meter with tolerance and stuck-input flags
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   measurement enable; low returns the meter to IDLE
//   err_clr     in   clears the sticky flags (a same-cycle set wins)
//   div_in      in   divided signal, synchronous to clk
//   high_time   out  last measured high duration in clk cycles
//   low_time    out  last measured low duration in clk cycles
//   period      out  high_time + low_time of the last measurement
//   meas_valid  out  one-cycle pulse when the duration outputs update
//   period_err  out  sticky: a measured period fell outside EXP_PERIOD +/- TOL
//   timeout     out  sticky: a duration counter saturated
module div_freq_meter
  import div_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             err_clr,
  input  logic             div_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             period_err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Lower bound clamps at zero when the tolerance exceeds the expected period.
  localparam int PER_LO = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam int PER_HI = EXP_PERIOD + TOL;

  state_t           state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic             rise;
  logic             fall;
  logic [CNT_W:0]   per_sum;
  logic             per_bad;

  div_edge_det u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_in (div_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign per_sum = {1'b0, hcnt} + {1'b0, lcnt};
  assign per_bad = (int'(per_sum) < PER_LO) || (int'(per_sum) > PER_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // Clear first so any set later in this block overrides it.
      if (err_clr) begin
        period_err <= 1'b0;
        timeout    <= 1'b0;
      end

      if (!en) begin
        state <= IDLE;
        hcnt  <= '0;
        lcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            hcnt  <= '0;
            lcnt  <= '0;
            state <= ARM;
          end
          // Whatever level is present on arming is partial; wait for a rise.
          ARM: begin
            if (rise) begin
              hcnt  <= CNT_W'(1);
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              lcnt  <= CNT_W'(1);
              state <= LOW;
            end else if (hcnt == CNT_MAX) begin
              timeout <= 1'b1;
              state   <= ARM;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          LOW: begin
            if (rise) begin
              high_time  <= hcnt;
              low_time   <= lcnt;
              period     <= per_sum;
              meas_valid <= 1'b1;
              if (per_bad) begin
                period_err <= 1'b1;
              end
              // The terminating rise starts the next high phase back-to-back.
              hcnt  <= CNT_W'(1);
              state <= HIGH;
            end else if (lcnt == CNT_MAX) begin
              timeout <= 1'b1;
              state   <= ARM;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_freq_meter.sv
// tb/tb_div_freq_meter.sv - randomized self-checking bench for div_freq_meter
module tb_div_freq_meter;

  localparam int CNT_W = 4;
  localparam int EXP   = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HI   = 2;
  localparam int M_LO   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic err_clr = 1'b0;
  logic div_in = 1'b0;

  logic [CNT_W-1:0] ht0, lt0, ht1, lt1;
  logic [CNT_W:0]   per0, per1;
  logic             mv0, pe0, to0, mv1, pe1, to1;

  div_freq_meter #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .err_clr(err_clr), .div_in(div_in),
    .high_time(ht0), .low_time(lt0), .period(per0),
    .meas_valid(mv0), .period_err(pe0), .timeout(to0)
  );

  div_freq_meter #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(1)) dut_tol1 (
    .clk(clk), .rst_n(rst_n), .en(en), .err_clr(err_clr), .div_in(div_in),
    .high_time(ht1), .low_time(lt1), .period(per1),
    .meas_valid(mv1), .period_err(pe1), .timeout(to1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: index k is the instance whose tolerance equals k.
  int  mode [2];
  int  t_rise [2];
  int  t_fall [2];
  int  e_ht [2];
  int  e_lt [2];
  int  e_per [2];
  bit  e_mv [2];
  bit  e_pe [2];
  bit  e_to [2];
  bit  prev_in;
  int  cyc;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_OFF; t_rise[k] = 0; t_fall[k] = 0;
      e_ht[k] = 0; e_lt[k] = 0; e_per[k] = 0;
      e_mv[k] = 1'b0; e_pe[k] = 1'b0; e_to[k] = 1'b0;
    end
    prev_in = 1'b0;
  endtask

  // Timestamp model: a measurement is rise-to-fall then fall-to-rise,
  // a level lasting beyond MAXC cycles raises timeout and re-arms.
  task automatic model_step();
    bit rise, fall;
    rise = div_in && !prev_in;
    fall = !div_in && prev_in;
    for (int k = 0; k < 2; k++) begin
      int lo, hi, p;
      hi = EXP + k;
      lo = (EXP > k) ? EXP - k : 0;
      e_mv[k] = 1'b0;
      if (err_clr) begin
        e_pe[k] = 1'b0;
        e_to[k] = 1'b0;
      end
      if (!en) begin
        mode[k] = M_OFF;
      end else if (mode[k] == M_OFF) begin
        mode[k] = M_WAIT;
      end else if (mode[k] == M_WAIT) begin
        if (rise) begin
          t_rise[k] = cyc;
          mode[k] = M_HI;
        end
      end else if (mode[k] == M_HI) begin
        if (fall) begin
          t_fall[k] = cyc;
          mode[k] = M_LO;
        end else if (cyc - t_rise[k] >= MAXC) begin
          e_to[k] = 1'b1;
          mode[k] = M_WAIT;
        end
      end else begin
        if (rise) begin
          e_ht[k] = t_fall[k] - t_rise[k];
          e_lt[k] = cyc - t_fall[k];
          p = cyc - t_rise[k];
          e_per[k] = p;
          e_mv[k] = 1'b1;
          if (p < lo || p > hi) e_pe[k] = 1'b1;
          t_rise[k] = cyc;
          mode[k] = M_HI;
        end else if (cyc - t_fall[k] >= MAXC) begin
          e_to[k] = 1'b1;
          mode[k] = M_WAIT;
        end
      end
    end
    prev_in = div_in;
    cyc++;
  endtask

  task automatic check_all();
    check("mv0", mv0, e_mv[0]);   check("mv1", mv1, e_mv[1]);
    check("ht0", ht0, e_ht[0]);   check("ht1", ht1, e_ht[1]);
    check("lt0", lt0, e_lt[0]);   check("lt1", lt1, e_lt[1]);
    check("per0", per0, e_per[0]); check("per1", per1, e_per[1]);
    check("pe0", pe0, e_pe[0]);   check("pe1", pe1, e_pe[1]);
    check("to0", to0, e_to[0]);   check("to1", to1, e_to[1]);
  endtask

  task automatic step(input bit r, input bit e, input bit c, input bit d);
    @(negedge clk);
    check_all();
    rst_n = r; en = e; err_clr = c; div_in = d;
    if (!r) model_reset();
    else model_step();
  endtask

  // clr_mode: 0 none, 1 err_clr on the rising cycle, 2 on the second high cycle
  task automatic wave(input int hi, input int lo, input int reps, input int clr_mode);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++)
        step(1'b1, 1'b1, (clr_mode == 1 && i == 0) || (clr_mode == 2 && i == 1), 1'b1);
      for (int i = 0; i < lo; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    check_all();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // divide-by-4 source
    wave(2, 2, 10, 0);
    check("div4_pe0", pe0, 0);
    check("div4_to0", to0, 0);

    // period 5: out of tolerance for TOL=0, inside for TOL=1
    wave(3, 2, 6, 0);
    check("p5_pe0", pe0, 1);
    check("p5_pe1", pe1, 0);

    // err_clr mid-high, then clean periods keep the flag clear
    wave(2, 2, 4, 2);
    check("clr_pe0", pe0, 0);

    // stuck high, then resume
    repeat (25) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("stuck_to0", to0, 1);
    wave(2, 2, 6, 0);
    check("resume_to0", to0, 1);

    // en dropped during LOW, then reasserted
    wave(2, 2, 4, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wave(2, 2, 5, 0);

    // err_clr coincident with an out-of-tolerance measurement
    wave(3, 2, 4, 1);
    check("setwins_pe0", pe0, 1);

    // asynchronous reset in the middle of a high phase
    wave(2, 2, 3, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    async_reset_pulse();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    wave(2, 2, 5, 0);

    // randomized levels, enable drops and clears
    repeat (150) begin
      int hl, ll;
      hl = $urandom_range(1, 18);
      ll = $urandom_range(1, 18);
      repeat (hl) step(1'b1, $urandom_range(0, 24) != 0, $urandom_range(0, 29) == 0, 1'b1);
      repeat (ll) step(1'b1, $urandom_range(0, 24) != 0, $urandom_range(0, 29) == 0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_freq_meter.md
Name: div_freq_meter

Overview:
- Downstream monitor for the clock-divider outputs.
- Takes a divided signal (div_in) generated in the same clk domain. Measures its high time, low time and period in clk cycles.
- Flags period deviation from an expected ratio and flags a stuck input.
- Used on-board and in simulation to qualify divider ratios (e.g. divide-by-4 gives period 4, high 2, low 2).

Parameters:
- CNT_W, 16: width of the high/low duration counters.
- EXP_PERIOD, 4: expected period in clk cycles.
- TOL, 0: allowed absolute deviation from EXP_PERIOD, in cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  measurement enable. Low forces IDLE.
- err_clr  in  1  single-cycle clear of the sticky flags.
- div_in  in  1  divided signal. Synchronous to clk; no synchronizer.
- high_time  out  CNT_W  last measured high duration.
- low_time  out  CNT_W  last measured low duration.
- period  out  CNT_W+1  high_time + low_time of the last measurement.
- meas_valid  out  1  one-cycle pulse when the three duration outputs update.
- period_err  out  1  sticky: a measured period was outside EXP_PERIOD ± TOL.
- timeout  out  1  sticky: a duration counter saturated.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, div_d 0.
- Edge detect:
  - div_d <= div_in every cycle.
  - rise = div_in & ~div_d, fall = ~div_in & div_d. Both combinational from the current div_in.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: counters cleared. Moves to ARM when en=1.
  - ARM: waits for rise. On rise, hcnt <= 1 and go to HIGH. The first partial cycle is never measured.
  - HIGH: on fall, lcnt <= 1 and go to LOW; otherwise hcnt++.
  - LOW, on rise:
    - latch high_time <= hcnt, low_time <= lcnt, period <= hcnt + lcnt (CNT_W+1 bits, no overflow).
    - meas_valid=1 for that cycle.
    - hcnt <= 1, stay back-to-back: go to HIGH.
  - LOW, otherwise: lcnt++.
- Cycle counting: the edge-detect cycle counts as cycle 1 of the new level. Duration outputs and meas_valid appear on the cycle after the terminating rise (registered).
- Saturation:
  - If hcnt or lcnt reaches all-ones while still counting, set timeout and go to ARM.
  - No meas_valid is issued; duration outputs hold their values.
- Error compare, evaluated on each valid measurement:
  - if period < EXP_PERIOD-TOL or period > EXP_PERIOD+TOL, set period_err together with meas_valid.
  - The lower bound clamps at 0.
- Sticky flags clear on err_clr. If set and clear occur in the same cycle, set wins.
- en deassert mid-measurement:
  - next cycle goes to IDLE, counters cleared, no meas_valid.
  - duration outputs and sticky flags hold.
- en reassert: enters ARM and discards the partial level.
- rst_n assert mid-operation: immediate return to reset values, regardless of clk.
- Constant div_in (0 or 1) with en=1: timeout after 2^CNT_W-1 cycles. Smaller CNT_W is used in test.
- Single-cycle pulses on div_in are legal: high_time=1.

Decomposition:
- Shared package div_pkg:
  - FSM state encodings (IDLE=2'd0, ARM=2'd1, HIGH=2'd2, LOW=2'd3).
  - default CNT_W.
- One sub-module, div_edge_det: holds the div_d register and produces rise/fall. It is reused by later divider-side blocks.
- Everything else stays in div_freq_meter: FSM, counters, compare and sticky flags.

Test Plan:
- Divide-by-4 source (toggle every 2 clk), EXP_PERIOD=4, en=1 -> from the second rise onward, meas_valid every 4 cycles with high=2, low=2, period=4, period_err=0.
- Source high 3 / low 2, EXP_PERIOD=4, TOL=0 -> period=5 and period_err=1 sticky. With TOL=1, period_err stays 0. A later err_clr pulse clears it.
- div_in held 1, CNT_W=4 -> timeout=1 after hcnt hits 15, FSM in ARM, no meas_valid. Resuming toggling gives valid measurements with timeout still 1.
- en dropped during LOW, then reasserted -> no meas_valid for the aborted period. Next valid measurement only after a full rise-to-rise cycle; prior outputs held meanwhile.
- err_clr asserted in the same cycle as an out-of-tolerance meas_valid -> period_err=1 afterward (set wins).
- rst_n pulsed low asynchronously mid-HIGH -> all outputs 0 immediately. After release, first meas_valid comes no earlier than the second rise.
